// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave in front of a small register file: write frames commit data,
// read frames arm an address then shift the register out on the following frame.
module spi_slave_regs #(
    parameter int unsigned CMD_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  loc_we,
    input  logic [ADDR_WIDTH-1:0] loc_addr,
    input  logic [DATA_WIDTH-1:0] loc_wdata,
    output logic                  wr_vld,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_done,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int unsigned NREG  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WR   = CNT_W'(CMD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(1 + ADDR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_ARMED   = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CMD_WIDTH-1:0]   sh_in;
    logic [DATA_WIDTH-1:0]  sh_out;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]  regs [NREG];

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_d;
    logic       cs_d;
    logic       cs_seen;

    // Synchronizers plus one history flop for edge detection. Everything resets
    // low so a cs already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
            cs_seen   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
            if (cs_sync[1]) cs_seen <= 1'b1;
        end
    end

    logic                  cs_s_c;
    logic                  mosi_s_c;
    logic                  sclk_rise_c;
    logic                  sclk_fall_c;
    logic                  cs_rise_c;
    logic                  cs_fall_c;
    logic [ADDR_WIDTH-1:0] cmd_addr_c;
    logic [DATA_WIDTH-1:0] cmd_data_c;
    logic                  spi_commit_c;
    logic                  arm_c;
    logic [DATA_WIDTH-1:0] rd_val_c;

    assign cs_s_c       = cs_sync[1];
    assign mosi_s_c     = mosi_sync[1];
    assign sclk_rise_c  = sclk_sync[1] & ~sclk_d;
    assign sclk_fall_c  = ~sclk_sync[1] & sclk_d;
    assign cs_rise_c    = cs_s_c & ~cs_d;
    assign cs_fall_c    = ~cs_s_c & cs_d;
    assign cmd_addr_c   = sh_in[CMD_WIDTH-2:DATA_WIDTH];
    assign cmd_data_c   = sh_in[DATA_WIDTH-1:0];
    assign spi_commit_c = (state == S_CMD) && cs_rise_c && (cnt == CNT_WR) && sh_in[CMD_WIDTH-1];
    assign arm_c        = (state == S_CMD) && cs_rise_c && (cnt == CNT_RD) && !sh_in[ADDR_WIDTH];

    // Write-first view of the armed register for the read shifter load.
    always_comb begin
        rd_val_c = regs[rd_addr];
        if (loc_we && (loc_addr == rd_addr)) rd_val_c = loc_wdata;
        if (spi_commit_c && (cmd_addr_c == rd_addr)) rd_val_c = cmd_data_c;
    end

    // Register file; the SPI commit is assigned last so it wins an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (loc_we) regs[loc_addr] <= loc_wdata;
            if (spi_commit_c) regs[cmd_addr_c] <= cmd_data_c;
        end
    end

    // Frame FSM with registered status pulses and miso.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            rd_addr   <= '0;
            miso      <= 1'b0;
            wr_vld    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_vld    <= 1'b0;
            rd_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= (cs_seen && !cs_s_c) || (state == S_ARMED) || arm_c;
            case (state)
                S_IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall_c) begin
                        cnt   <= '0;
                        sh_in <= '0;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    miso <= 1'b0;
                    if (cs_rise_c) begin
                        state <= S_IDLE;
                        if (spi_commit_c) begin
                            wr_vld  <= 1'b1;
                            wr_addr <= cmd_addr_c;
                            wr_data <= cmd_data_c;
                        end else if (arm_c) begin
                            rd_addr <= sh_in[ADDR_WIDTH-1:0];
                            state   <= S_ARMED;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise_c) begin
                        sh_in <= {sh_in[CMD_WIDTH-2:0], mosi_s_c};
                        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    miso <= 1'b0;
                    if (cs_fall_c) begin
                        cnt    <= '0;
                        sh_out <= rd_val_c;
                        miso   <= rd_val_c[DATA_WIDTH-1];
                        state  <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (cs_rise_c) begin
                        miso  <= 1'b0;
                        state <= S_IDLE;
                        if (cnt >= CNT_DATA) rd_done <= 1'b1;
                        else frame_err <= 1'b1;
                    end else begin
                        // Zeros shift in behind the data, so miso idles low after the last bit.
                        if (sclk_fall_c) begin
                            sh_out <= {sh_out[DATA_WIDTH-2:0], 1'b0};
                            miso   <= sh_out[DATA_WIDTH-2];
                        end
                        if (sclk_rise_c && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed frame table, clash/reset sequences, and
// random frames checked against a frame-level model of the register file.
module tb_spi_slave_regs;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int CW = 12;
    localparam int H  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          loc_we = 1'b0;
    logic [AW-1:0] loc_addr = '0;
    logic [DW-1:0] loc_wdata = '0;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_done;
    logic          frame_err;
    logic          busy;

    spi_slave_regs #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_done(rd_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cnt_wr = 0;
    int cnt_rd = 0;
    int cnt_err = 0;

    always @(negedge clk) begin
        if (wr_vld) cnt_wr++;
        if (rd_done) cnt_rd++;
        if (frame_err) cnt_err++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: register array plus armed flag.
    logic [DW-1:0] m_regs [8];
    bit            m_armed;
    logic [AW-1:0] m_rd_addr;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_armed = 0;
        m_rd_addr = '0;
        m_wa = '0;
        m_wd = '0;
    endtask

    task automatic model_frame(input logic [63:0] bits, input int n,
                               output int e_wr, output int e_rd, output int e_err,
                               output logic [63:0] e_miso);
        logic [DW-1:0] v;
        e_wr = 0; e_rd = 0; e_err = 0; e_miso = '0;
        if (m_armed) begin
            v = m_regs[m_rd_addr];
            for (int i = 0; i < n && i < DW; i++)
                e_miso[6'(n - 1 - i)] = v[3'(DW - 1 - i)];
            if (n >= DW) e_rd = 1;
            else e_err = 1;
            m_armed = 0;
        end else if (n == CW && bits[CW-1]) begin
            m_wa = AW'(bits >> DW);
            m_wd = DW'(bits);
            m_regs[m_wa] = m_wd;
            e_wr = 1;
        end else if (n == 1 + AW && !bits[AW]) begin
            m_armed = 1;
            m_rd_addr = AW'(bits);
        end else begin
            e_err = 1;
        end
    endtask

    task automatic do_frame(input logic [63:0] bits, input int n, input bit hold_loc,
                            output logic [63:0] got_miso, output logic busy_mid);
        got_miso = '0;
        @(negedge clk);
        cnt_wr = 0; cnt_rd = 0; cnt_err = 0;
        cs = 1'b0;
        wait_clk(H);
        busy_mid = busy;
        for (int i = 0; i < n; i++) begin
            mosi = bits[6'(n - 1 - i)];
            wait_clk(H);
            got_miso[6'(n - 1 - i)] = miso;
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(H);
        cs = 1'b1;
        mosi = 1'b0;
        if (hold_loc) begin
            loc_we = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (wr_vld) break;
            end
            loc_we = 1'b0;
        end
        wait_clk(10);
    endtask

    task automatic run_check(input string tag, input logic [63:0] bits, input int n, input bit hold,
                             input int e_wr, input int e_rd, input int e_err, input logic [63:0] e_miso,
                             input logic e_busy, input logic [7:0] e_wa, input logic [7:0] e_wd);
        logic [63:0] gm;
        logic        bm;
        do_frame(bits, n, hold, gm, bm);
        check({tag, " busy_mid"}, 64'(bm), 64'(1));
        check({tag, " wr_vld_cycles"}, 64'(cnt_wr), 64'(e_wr));
        check({tag, " rd_done_cycles"}, 64'(cnt_rd), 64'(e_rd));
        check({tag, " frame_err_cycles"}, 64'(cnt_err), 64'(e_err));
        check({tag, " miso_bits"}, gm, e_miso);
        check({tag, " busy_after"}, 64'(busy), 64'(e_busy));
        check({tag, " wr_addr"}, 64'(wr_addr), 64'(e_wa));
        check({tag, " wr_data"}, 64'(wr_data), 64'(e_wd));
    endtask

    task automatic run_model(input string tag, input logic [63:0] bits, input int n);
        int          e_wr, e_rd, e_err;
        logic [63:0] e_miso;
        model_frame(bits, n, e_wr, e_rd, e_err, e_miso);
        run_check(tag, bits, n, 1'b0, e_wr, e_rd, e_err, e_miso, m_armed, 8'(m_wa), 8'(m_wd));
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        loc_addr = a;
        loc_wdata = d;
        loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        m_regs[a] = d;
    endtask

    typedef struct {
        logic [63:0] bits;
        int          n;
        int          wr;
        int          rd;
        int          err;
        logic [63:0] miso;
        logic        busy;
        logic [7:0]  wa;
        logic [7:0]  wd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int          e_wr, e_rd, e_err, kind, n;
        logic [63:0] e_miso, b;

        tbl[0]  = '{64'hA5C,         12, 1, 0, 0, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[1]  = '{64'h2,            4, 0, 0, 0, 64'h0,   1'b1, 8'd2, 8'h5C};
        tbl[2]  = '{64'h0,            8, 0, 1, 0, 64'h5C,  1'b0, 8'd2, 8'h5C};
        tbl[3]  = '{64'h55,           7, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[4]  = '{64'h2,            4, 0, 0, 0, 64'h0,   1'b1, 8'd2, 8'h5C};
        tbl[5]  = '{64'h1F,           5, 0, 0, 1, 64'h0B,  1'b0, 8'd2, 8'h5C};
        tbl[6]  = '{64'h0,            8, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[7]  = '{64'h0,            0, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[8]  = '{64'hFF_FFFF_FFFF, 40, 0, 0, 1, 64'h0,  1'b0, 8'd2, 8'h5C};
        tbl[9]  = '{64'h2,            4, 0, 0, 0, 64'h0,   1'b1, 8'd2, 8'h5C};
        tbl[10] = '{64'h0,           12, 0, 1, 0, 64'h5C0, 1'b0, 8'd2, 8'h5C};
        tbl[11] = '{64'hB,            4, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[12] = '{64'h25C,         12, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[13] = '{64'h2,            5, 0, 0, 1, 64'h0,   1'b0, 8'd2, 8'h5C};
        tbl[14] = '{64'hBAA,         12, 1, 0, 0, 64'h0,   1'b0, 8'd3, 8'hAA};
        tbl[15] = '{64'h3,            4, 0, 0, 0, 64'h0,   1'b1, 8'd3, 8'hAA};
        tbl[16] = '{64'h0,            8, 0, 1, 0, 64'hAA,  1'b0, 8'd3, 8'hAA};

        model_reset();

        // Reset values, then release with cs idle high.
        wait_clk(3);
        check("rst miso", 64'(miso), 64'(0));
        check("rst wr_vld", 64'(wr_vld), 64'(0));
        check("rst rd_done", 64'(rd_done), 64'(0));
        check("rst frame_err", 64'(frame_err), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst wr_addr", 64'(wr_addr), 64'(0));
        check("rst wr_data", 64'(wr_data), 64'(0));
        rst_n = 1'b1;
        wait_clk(8);
        check("post_rst busy", 64'(busy), 64'(0));

        for (int i = 0; i < 17; i++) begin
            model_frame(tbl[i].bits, tbl[i].n, e_wr, e_rd, e_err, e_miso);
            run_check($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].n, 1'b0,
                      tbl[i].wr, tbl[i].rd, tbl[i].err, tbl[i].miso,
                      tbl[i].busy, tbl[i].wa, tbl[i].wd);
        end

        // SPI commit and local write to the same address in the same cycle.
        loc_addr = 3'd2;
        loc_wdata = 8'h11;
        model_frame(64'hA5C, 12, e_wr, e_rd, e_err, e_miso);
        run_check("clash_wr", 64'hA5C, 12, 1'b1, 1, 0, 0, 64'h0, 1'b0, 8'd2, 8'h5C);
        m_regs[2] = 8'h5C;
        run_check("clash_rcmd", 64'h2, 4, 1'b0, 0, 0, 0, 64'h0, 1'b1, 8'd2, 8'h5C);
        run_check("clash_rdat", 64'h0, 8, 1'b0, 0, 1, 0, 64'h5C, 1'b0, 8'd2, 8'h5C);
        loc_write(3'd3, 8'h11);
        run_check("loc_rcmd", 64'h3, 4, 1'b0, 0, 0, 0, 64'h0, 1'b1, 8'd2, 8'h5C);
        run_check("loc_rdat", 64'h0, 8, 1'b0, 0, 1, 0, 64'h11, 1'b0, 8'd2, 8'h5C);
        m_armed = 0;

        // Random frames and local writes against the model.
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 5));
            if (kind == 5) begin
                loc_write(AW'($urandom), DW'($urandom));
            end else begin
                if (m_armed) begin
                    n = int'($urandom_range(0, 12));
                    b = {$urandom, $urandom};
                end else if (kind <= 1) begin
                    n = CW;
                    b = 64'({1'b1, 3'($urandom), 8'($urandom)});
                end else if (kind <= 3) begin
                    n = 1 + AW;
                    b = 64'({1'b0, 3'($urandom)});
                end else begin
                    n = int'($urandom_range(0, 36));
                    b = {$urandom, $urandom};
                end
                run_model($sformatf("rnd%0d", it), b, n);
            end
        end

        // Reset in the middle of a write frame of 0xFFF.
        if (m_armed) run_model("rnd_flush", 64'h0, 8);
        @(negedge clk);
        cnt_wr = 0;
        cs = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 6; i++) begin
            mosi = 1'b1;
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(2);
        check("midrst miso", 64'(miso), 64'(0));
        check("midrst wr_data", 64'(wr_data), 64'(0));
        rst_n = 1'b1;
        model_reset();
        wait_clk(4);
        for (int i = 0; i < 6; i++) begin
            wait_clk(H);
            check($sformatf("midrst tail miso%0d", i), 64'(miso), 64'(0));
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(H);
        cs = 1'b1;
        mosi = 1'b0;
        wait_clk(10);
        check("midrst wr_vld_cycles", 64'(cnt_wr), 64'(0));
        check("midrst wr_addr", 64'(wr_addr), 64'(0));
        run_check("midrst r7cmd", 64'h7, 4, 1'b0, 0, 0, 0, 64'h0, 1'b1, 8'd0, 8'd0);
        run_check("midrst r7dat", 64'h0, 8, 1'b0, 0, 1, 0, 64'h0, 1'b0, 8'd0, 8'd0);
        m_armed = 0;
        run_check("midrst wFFF", 64'hFFF, 12, 1'b0, 1, 0, 0, 64'h0, 1'b0, 8'd7, 8'hFF);
        m_regs[7] = 8'hFF;
        run_check("midrst r7cmd2", 64'h7, 4, 1'b0, 0, 0, 0, 64'h0, 1'b1, 8'd7, 8'hFF);
        run_check("midrst r7dat2", 64'h0, 8, 1'b0, 0, 1, 0, 64'hFF, 1'b0, 8'd7, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 Parameter CMD_WIDTH, default 12, command frame length in bits; SHALL equal 1+ADDR_WIDTH+DATA_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 3, register address width, giving 2**ADDR_WIDTH registers.
REQ-003 Parameter DATA_WIDTH, default 8, register and read-frame width.
REQ-004 clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sclk  input  1  SPI clock from master, idle low, asynchronous to clk.
REQ-007 cs  input  1  chip select from master, active-low, asynchronous.
REQ-008 mosi  input  1  serial data from master.
REQ-009 miso  output  1  serial data to master.
REQ-010 loc_we  input  1  local register write strobe.
REQ-011 loc_addr  input  ADDR_WIDTH  local write address.
REQ-012 loc_wdata  input  DATA_WIDTH  local write data.
REQ-013 wr_vld  output  1  one-cycle pulse: SPI write committed.
REQ-014 wr_addr/wr_data  output  ADDR_WIDTH/DATA_WIDTH  address/data of last SPI write, held until next commit.
REQ-015 rd_done  output  1  one-cycle pulse: read frame completed with all 8 bits.
REQ-016 frame_err  output  1  one-cycle pulse: malformed frame discarded.
REQ-017 busy  output  1  high while cs is low (synchronized) or a read is armed.

Function
REQ-018 sclk, cs and mosi SHALL pass through 2-flop synchronizers; edges are detected on synchronized values; master sclk high/low phases are at least 3 clk.
REQ-019 Protocol is SPI mode 0, MSB first: mosi is sampled on detected sclk rise; miso changes on detected sclk fall.
REQ-020 Command word: bit CMD_WIDTH-1 = W (1 write, 0 read), next ADDR_WIDTH bits = address, low DATA_WIDTH bits = write data.
REQ-021 FSM states: IDLE, CMD (shifting command), ARMED (read address latched, waiting for data frame), RD_DATA (shifting out).
REQ-022 IDLE -> CMD on cs fall detected; bit counter (5 bits, saturating at 31) is cleared.
REQ-023 CMD: each sclk rise shifts mosi into shift register and increments bit counter.
REQ-024 CMD on cs rise: count==CMD_WIDTH and W=1 -> write register, wr_vld pulse in next cycle, -> IDLE.
REQ-025 CMD on cs rise: count==1+ADDR_WIDTH and W=0 -> latch read address, -> ARMED.
REQ-026 CMD on cs rise, any other count/W combination (incl. 0 bits) -> frame_err pulse in next cycle, no register change, -> IDLE.
REQ-027 ARMED -> RD_DATA on cs fall; register[rd_addr] copied to output shifter in the same cycle, MSB driven on miso within 1 clk of cs-fall detection.
REQ-028 RD_DATA: each sclk fall shifts next bit out; after DATA_WIDTH bits miso SHALL be 0; mosi ignored.
REQ-029 RD_DATA on cs rise: count>=DATA_WIDTH -> rd_done pulse; else frame_err pulse; both -> IDLE, armed cleared.
REQ-030 miso SHALL be 0 in every state other than RD_DATA.
REQ-031 loc_we writes register[loc_addr] in any state; when an SPI commit and loc_we hit the same address in the same cycle, SPI data wins.
REQ-032 A register read for RD_DATA samples the value written by any commit in the same cycle (write-first).
REQ-033 Bit counter saturates; frames longer than 31 bits are still rejected per REQ-026.

Reset
REQ-034 On rst_n low: state IDLE, all registers 0, shifters/counters 0, miso 0, wr_vld 0, rd_done 0, frame_err 0, busy 0, wr_addr 0, wr_data 0.
REQ-035 Reset asserted mid-frame aborts the frame with no commit; after release the block waits for a fresh cs fall (cs already low at release is not a frame start).

Verification
REQ-036 Write frame 0xA5C (W=1, addr 2, data 0x5C) -> wr_vld one cycle, wr_addr=2, wr_data=0x5C, register 2 = 0x5C.
REQ-037 After REQ-036, 4-bit frame 0b0010 then 8-clock frame -> miso 0,1,0,1,1,1,0,0, rd_done one pulse, busy low after.
REQ-038 7-bit frame 0x55 with W=1 -> frame_err pulse, no wr_vld, all registers unchanged.
REQ-039 Armed read of address 2, data frame cut after 5 bits -> frame_err pulse, state IDLE, next 8-bit frame returns miso all 0.
REQ-040 loc_we addr 2 data 0x11 in the same cycle as SPI commit of 0x5C to addr 2 -> register 2 = 0x5C; a separate loc_we 0x11 to addr 3 -> readback 0x11.
REQ-041 rst_n pulsed after 6 bits of write frame 0xFFF -> no wr_vld, register 7 = 0, miso 0, frame following the next cs fall decoded normally.
